// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave front-panel controller.
//   state_t           : FSM state encoding (IDLE/COOKING/PAUSED/DONE)
//   TICKS_PER_SEC_DEF : default clock cycles per one-second timer decrement
//   DONE_CYCLES_DEF   : default clock cycles the DONE (beep) state is held
//   cnt_w()           : bit width needed for a counter running 0..n-1
package microwave_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COOKING = 2'd1,
    PAUSED  = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int unsigned TICKS_PER_SEC_DEF = 50_000_000;
  localparam int unsigned DONE_CYCLES_DEF   = 100_000_000;

  // A counter spanning 0..n-1 needs clog2(n) bits; never go below 1 bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/microwave_control_if.sv
// Front-panel / timer signal bundle for microwave_control.
//   start, stop     : panel buttons (levels)
//   door_closed     : door sensor, 1 = shut
//   timer_done      : from timer, 1 = count at 00:00
//   timer_enable    : one-cycle decrement pulse to the timer
//   timer_loadn     : 0 = timer digit entry allowed
//   timer_clearn    : active-low one-cycle timer clear
//   mag_on          : magnetron drive
//   beep            : buzzer (only when MICROWAVE_BEEP_EN is defined)
// Modports: slave = controller side, master = panel/timer side.
interface microwave_control_if;

  logic start;
  logic stop;
  logic door_closed;
  logic timer_done;
  logic timer_enable;
  logic timer_loadn;
  logic timer_clearn;
  logic mag_on;
`ifdef MICROWAVE_BEEP_EN
  logic beep;
`endif

  modport slave (
    input  start, stop, door_closed, timer_done,
`ifdef MICROWAVE_BEEP_EN
    output beep,
`endif
    output timer_enable, timer_loadn, timer_clearn, mag_on
  );

  modport master (
    output start, stop, door_closed, timer_done,
`ifdef MICROWAVE_BEEP_EN
    input  beep,
`endif
    input  timer_enable, timer_loadn, timer_clearn, mag_on
  );

endinterface

// File: rtl/microwave_control_rise_detect.sv
// Rising-edge detector: one register of the input plus an AND.
//   clk   : clock
//   clear : synchronous active-high reset
//   in    : level input
//   evt   : 1 while in is high and was low at the previous edge
module rise_detect (
  input  logic clk,
  input  logic clear,
  input  logic in,
  output logic evt
);

  logic in_q;

  always_ff @(posedge clk) begin
    if (clear) in_q <= 1'b0;
    else       in_q <= in;
  end

  assign evt = in & ~in_q;

endmodule

// File: rtl/microwave_control.sv
// Microwave front-panel control unit. Sequences magnetron, timer load/clear
// and the 1 Hz timer decrement from start/stop buttons and the door sensor.
//   CLK   : system clock (rising edge)
//   clear : synchronous active-high reset
//   bus   : microwave_control_if.slave (panel inputs, timer/magnetron outputs)
// Parameters: TICKS_PER_SEC (cycles per decrement, >= 2),
//             DONE_CYCLES (cycles DONE is held when the beeper is built in).
// Build option: MICROWAVE_BEEP_EN adds the beep output and the DONE hold
// counter; without it DONE lasts a single cycle.
module microwave_control
  import microwave_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = TICKS_PER_SEC_DEF,
  parameter int unsigned DONE_CYCLES   = DONE_CYCLES_DEF
) (
  input logic                CLK,
  input logic                clear,
  microwave_control_if.slave bus
);

  localparam int unsigned   TW       = cnt_w(TICKS_PER_SEC);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_SEC - 1);

  if (TICKS_PER_SEC < 2 || DONE_CYCLES < 1) begin : g_bad_param
    $error("microwave_control: TICKS_PER_SEC must be >= 2 and DONE_CYCLES >= 1");
  end

  logic start_evt;
  logic stop_evt;

  rise_detect u_start_rise (
    .clk   (CLK),
    .clear (clear),
    .in    (bus.start),
    .evt   (start_evt)
  );

  rise_detect u_stop_rise (
    .clk   (CLK),
    .clear (clear),
    .in    (bus.stop),
    .evt   (stop_evt)
  );

  logic          start_evt_p0;
  logic          stop_evt_p0;
  state_t        state_p1;
  state_t        state_nxt;
  logic [TW-1:0] tick_p1;
  logic [TW-1:0] tick_nxt;
  logic          enable_nxt;
  logic          clearn_nxt;
  logic          timer_enable_p1;
  logic          timer_loadn_p1;
  logic          timer_clearn_p1;
  logic          mag_on_p1;

`ifdef MICROWAVE_BEEP_EN
  localparam int unsigned   HW       = cnt_w(DONE_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(DONE_CYCLES - 1);
  logic [HW-1:0] hold_p1;
  logic [HW-1:0] hold_nxt;
  logic          beep_p1;
`endif

  // Stage p0: button events are registered before the FSM acts on them.
  always_ff @(posedge CLK) begin
    if (clear) begin
      start_evt_p0 <= 1'b0;
      stop_evt_p0  <= 1'b0;
    end else begin
      start_evt_p0 <= start_evt;
      stop_evt_p0  <= stop_evt;
    end
  end

  // Next-state and next-output decode. Door and timer_done are used raw so
  // an opened door drops the magnetron on the very next edge.
  always_comb begin
    state_nxt  = state_p1;
    tick_nxt   = tick_p1;
    enable_nxt = 1'b0;
    clearn_nxt = 1'b1;
`ifdef MICROWAVE_BEEP_EN
    hold_nxt   = '0;
`endif
    unique case (state_p1)
      IDLE: begin
        if (stop_evt_p0) begin
          clearn_nxt = 1'b0;
        end else if (start_evt_p0 && bus.door_closed && !bus.timer_done) begin
          state_nxt = COOKING;
          tick_nxt  = '0;
        end
      end
      COOKING: begin
        if (!bus.door_closed) begin
          state_nxt = PAUSED;
        end else if (bus.timer_done) begin
          // Leaving for DONE suppresses a decrement that would wrap here.
          state_nxt = DONE;
        end else if (stop_evt_p0) begin
          state_nxt = PAUSED;
        end else if (tick_p1 == TICK_MAX) begin
          tick_nxt   = '0;
          enable_nxt = 1'b1;
        end else begin
          tick_nxt = tick_p1 + TW'(1);
        end
      end
      PAUSED: begin
        // Tick counter holds so a resume finishes the partial second.
        if (stop_evt_p0) begin
          state_nxt  = IDLE;
          clearn_nxt = 1'b0;
        end else if (start_evt_p0 && bus.door_closed) begin
          state_nxt = COOKING;
        end
      end
      DONE: begin
        if (stop_evt_p0) begin
          state_nxt = IDLE;
        end else begin
`ifdef MICROWAVE_BEEP_EN
          if (hold_p1 == HOLD_MAX) state_nxt = IDLE;
          else                     hold_nxt  = hold_p1 + HW'(1);
`else
          state_nxt = IDLE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: state, counters and all outputs registered together.
  always_ff @(posedge CLK) begin
    if (clear) begin
      state_p1        <= IDLE;
      tick_p1         <= '0;
      timer_enable_p1 <= 1'b0;
      timer_loadn_p1  <= 1'b0;
      timer_clearn_p1 <= 1'b1;
      mag_on_p1       <= 1'b0;
`ifdef MICROWAVE_BEEP_EN
      hold_p1         <= '0;
      beep_p1         <= 1'b0;
`endif
    end else begin
      state_p1        <= state_nxt;
      tick_p1         <= tick_nxt;
      timer_enable_p1 <= enable_nxt;
      timer_loadn_p1  <= (state_nxt != IDLE);
      timer_clearn_p1 <= clearn_nxt;
      mag_on_p1       <= (state_nxt == COOKING);
`ifdef MICROWAVE_BEEP_EN
      hold_p1         <= hold_nxt;
      beep_p1         <= (state_nxt == DONE);
`endif
    end
  end

  assign bus.timer_enable = timer_enable_p1;
  assign bus.timer_loadn  = timer_loadn_p1;
  assign bus.timer_clearn = timer_clearn_p1;
  assign bus.mag_on       = mag_on_p1;
`ifdef MICROWAVE_BEEP_EN
  assign bus.beep         = beep_p1;
`endif

endmodule

// File: tb/tb_microwave_control.sv
// Directed bench for microwave_control with TICKS_PER_SEC=4, DONE_CYCLES=3.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_microwave_control;

  logic clk;
  logic clear;
  int   checks;
  int   errors;

  microwave_control_if bus ();

  microwave_control #(
    .TICKS_PER_SEC (4),
    .DONE_CYCLES   (3)
  ) dut (
    .CLK   (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    clear           = 1'b1;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.door_closed = 1'b1;
    bus.timer_done  = 1'b0;

    // Reset
    cyc();
    cyc();
    chk("rst_mag_on", bus.mag_on, 1'b0);
    chk("rst_enable", bus.timer_enable, 1'b0);
    chk("rst_loadn", bus.timer_loadn, 1'b0);
    chk("rst_clearn", bus.timer_clearn, 1'b1);
`ifdef MICROWAVE_BEEP_EN
    chk("rst_beep", bus.beep, 1'b0);
`endif
    clear = 1'b0;
    cyc();

    // Normal cook: event edge, then COOKING one edge later
    bus.start = 1'b1;
    cyc();
    chk("cook_evt_mag_on", bus.mag_on, 1'b0);
    bus.start = 1'b0;
    cyc();
    chk("cook_entry_mag_on", bus.mag_on, 1'b1);
    chk("cook_entry_loadn", bus.timer_loadn, 1'b1);
    chk("cook_entry_enable", bus.timer_enable, 1'b0);
    for (int k = 1; k <= 11; k++) begin
      cyc();
      chk($sformatf("cook_enable_k%0d", k), bus.timer_enable, (k % 4) == 0);
    end
    // timer_done lands on what would be a wrap edge: no pulse, go DONE
    bus.timer_done = 1'b1;
    cyc();
    chk("done_mag_on", bus.mag_on, 1'b0);
    chk("done_enable", bus.timer_enable, 1'b0);
    chk("done_loadn", bus.timer_loadn, 1'b1);
`ifdef MICROWAVE_BEEP_EN
    chk("done_beep0", bus.beep, 1'b1);
    cyc();
    chk("done_beep1", bus.beep, 1'b1);
    chk("done_loadn1", bus.timer_loadn, 1'b1);
    cyc();
    chk("done_beep2", bus.beep, 1'b1);
    cyc();
    chk("done_exit_beep", bus.beep, 1'b0);
    chk("done_exit_loadn", bus.timer_loadn, 1'b0);
`else
    cyc();
    chk("done_exit_loadn", bus.timer_loadn, 1'b0);
`endif

    // Start refused with timer_done=1
    bus.start = 1'b1;
    cyc();
    cyc();
    chk("refuse_done_mag_on", bus.mag_on, 1'b0);
    chk("refuse_done_loadn", bus.timer_loadn, 1'b0);
    bus.start      = 1'b0;
    bus.timer_done = 1'b0;
    bus.door_closed = 1'b0;
    cyc();
    // Start refused with door open
    bus.start = 1'b1;
    cyc();
    cyc();
    chk("refuse_door_mag_on", bus.mag_on, 1'b0);
    chk("refuse_door_loadn", bus.timer_loadn, 1'b0);
    bus.start       = 1'b0;
    bus.door_closed = 1'b1;
    cyc();

    // Cancel in IDLE: single-cycle clear even with stop held
    bus.stop = 1'b1;
    cyc();
    chk("idle_stop_evt_clearn", bus.timer_clearn, 1'b1);
    cyc();
    chk("idle_stop_clearn_low", bus.timer_clearn, 1'b0);
    cyc();
    chk("idle_stop_clearn_back", bus.timer_clearn, 1'b1);
    bus.stop = 1'b0;
    cyc();

    // Door interlock
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
    chk("door_cook_mag_on", bus.mag_on, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk($sformatf("door_cook_enable_k%0d", k), bus.timer_enable, (k % 4) == 0);
    end
    bus.door_closed = 1'b0;
    cyc();
    chk("door_open_mag_on", bus.mag_on, 1'b0);
    chk("door_open_loadn", bus.timer_loadn, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk($sformatf("paused_enable_k%0d", k), bus.timer_enable, 1'b0);
      chk($sformatf("paused_mag_on_k%0d", k), bus.mag_on, 1'b0);
    end
    bus.door_closed = 1'b1;
    bus.start       = 1'b1;
    cyc();
    chk("resume_evt_mag_on", bus.mag_on, 1'b0);
    bus.start = 1'b0;
    cyc();
    chk("resume_mag_on", bus.mag_on, 1'b1);
    chk("resume_enable0", bus.timer_enable, 1'b0);
    cyc();
    chk("resume_enable1", bus.timer_enable, 1'b0);
    cyc();
    chk("resume_enable2", bus.timer_enable, 1'b1);

    // Start and stop together while cooking: stop wins -> PAUSED
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    cyc();
    chk("both_evt_mag_on", bus.mag_on, 1'b1);
    cyc();
    chk("both_mag_on", bus.mag_on, 1'b0);
    chk("both_loadn", bus.timer_loadn, 1'b1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    cyc();

    // Cancel from PAUSED
    bus.stop = 1'b1;
    cyc();
    chk("pause_stop_evt_clearn", bus.timer_clearn, 1'b1);
    chk("pause_stop_evt_loadn", bus.timer_loadn, 1'b1);
    bus.stop = 1'b0;
    cyc();
    chk("pause_stop_loadn", bus.timer_loadn, 1'b0);
    chk("pause_stop_clearn_low", bus.timer_clearn, 1'b0);
    chk("pause_stop_mag_on", bus.mag_on, 1'b0);
    cyc();
    chk("pause_stop_clearn_back", bus.timer_clearn, 1'b1);

    // Reset mid-cook, on the edge that would otherwise issue a decrement
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
    chk("midrst_cook_mag_on", bus.mag_on, 1'b1);
    cyc();
    cyc();
    cyc();
    clear = 1'b1;
    cyc();
    chk("midrst_mag_on", bus.mag_on, 1'b0);
    chk("midrst_loadn", bus.timer_loadn, 1'b0);
    chk("midrst_enable", bus.timer_enable, 1'b0);
    chk("midrst_clearn", bus.timer_clearn, 1'b1);
    clear = 1'b0;
    cyc();
    chk("midrst_idle_loadn", bus.timer_loadn, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/microwave_control.md
# microwave_control

Control unit for the microwave front panel. It sits directly downstream of `timer_nivel2`: it consumes the timer's `timer_done` and drives the timer's `enable`, `loadn` and `clearn` inputs. It also sequences the magnetron output and the end-of-cook beep from the panel start/stop buttons and the door sensor. It generates a once-per-second decrement pulse for the timer from the system clock.

## Interface
Parameters:
- `TICKS_PER_SEC`, default 50_000_000: CLK cycles per timer decrement; legal range ≥ 2.
- `DONE_CYCLES`, default 100_000_000: CLK cycles the DONE state is held.

Ports:
- `CLK`  in  1  system clock; all logic updates on its rising edge.
- `clear`  in  1  synchronous, active-high reset.
- `start`  in  1  start button, level; acted on at its rising edge.
- `stop`  in  1  stop/cancel button, level; acted on at its rising edge.
- `door_closed`  in  1  1 = door shut.
- `timer_done`  in  1  from timer, 1 = count is at 00:00.
- `timer_enable`  out  1  one-cycle decrement pulse to timer `enable`.
- `timer_loadn`  out  1  to timer `loadn`; 0 = digit entry allowed.
- `timer_clearn`  out  1  to timer `clearn`; active-low one-cycle clear pulse.
- `mag_on`  out  1  magnetron drive.
- `beep`  out  1  buzzer; present only with `MICROWAVE_BEEP_EN`.

## Operation
- **Edge detection.** `start` and `stop` are registered once. An event is `in & ~in_q`.
- **States:** IDLE, COOKING, PAUSED, DONE.
- **IDLE**
  - Outputs: `timer_loadn`=0, `mag_on`=0.
  - Start event with `door_closed`=1 and `timer_done`=0 → COOKING. The tick counter is zeroed.
  - Stop event → stays in IDLE and pulses `timer_clearn`=0 for 1 cycle, which cancels the entered digits.
  - Start event with the door open or `timer_done`=1 is ignored.
- **COOKING**
  - Outputs: `mag_on`=1, `timer_loadn`=1.
  - The tick counter counts 0..`TICKS_PER_SEC`-1 and wraps. `timer_enable`=1 in the cycle the counter wraps.
- **PAUSED**
  - Outputs: `mag_on`=0, `timer_loadn`=1, `timer_enable`=0.
  - The tick counter holds its value, so resuming continues the partial second.
  - Start event with `door_closed`=1 → COOKING.
  - Stop event → IDLE with a `timer_clearn` pulse.
- **DONE**
  - Outputs: `mag_on`=0, `timer_loadn`=1.
  - A hold counter runs `DONE_CYCLES` cycles, then the block returns to IDLE.
  - Stop event → IDLE immediately.
- **COOKING exit priority** (highest first):
  1. `clear`.
  2. `door_closed`=0 → PAUSED.
  3. `timer_done`=1 → DONE; no `timer_enable` pulse is issued in that cycle.
  4. Stop event → PAUSED.
- **Simultaneous start and stop events in any state:** stop wins.
- **`timer_done` already 1 on entry to COOKING:** handled as priority rule 3 on the next cycle.

## Timing
- **All outputs are registered.** After `clear`, the registered state is:
  - `mag_on`=0, `timer_enable`=0, `timer_loadn`=0, `timer_clearn`=1, `beep`=0.
  - State IDLE; both counters and both edge registers 0.
- **Start-to-cook latency.** A start rising edge sampled at edge N registers the event. The state becomes COOKING and `mag_on`=1 at edge N+1.
- **First decrement.** The first `timer_enable` pulse comes `TICKS_PER_SEC` cycles after the COOKING entry edge. Later pulses are spaced exactly `TICKS_PER_SEC` apart, excluding PAUSED time.
- **Door open.** `mag_on` falls on the first edge that samples `door_closed`=0. There is no edge-register delay on the door input.
- **Clear pulse.** `timer_clearn` is low for exactly 1 cycle, starting at the edge after the stop event.
- **`clear` asserted mid-operation** forces the reset values at the next edge, regardless of state.

## Configuration
- **Macro:** `MICROWAVE_BEEP_EN`.
- **Defined:**
  - The `beep` port exists.
  - `beep`=1 throughout DONE and is registered together with the state.
  - DONE lasts `DONE_CYCLES` cycles.
- **Undefined:**
  - No `beep` port and no hold counter.
  - DONE lasts exactly 1 cycle, then IDLE.

## Structure
- **Package `microwave_pkg`:**
  - State encoding constants: IDLE=2'd0, COOKING=2'd1, PAUSED=2'd2, DONE=2'd3.
  - Default values of `TICKS_PER_SEC` and `DONE_CYCLES`.
  - Counter width derivation through a `$clog2`-based constant function.
- **Sub-module `rise_detect`:** 1-bit register plus AND, with synchronous active-high `clear`. It is instantiated twice, once for `start` and once for `stop`.
- **FSM, tick counter and hold counter** live in `microwave_control`.

## Test plan
All scenarios use `TICKS_PER_SEC`=4 and `DONE_CYCLES`=3.
- **Reset:** `clear`=1 for 2 cycles → all outputs at their reset values, `timer_loadn`=0.
- **Normal cook:** door closed, `timer_done`=0, start pulse → `mag_on`=1 one edge later. `timer_enable` pulses every 4 cycles. Raising `timer_done` → `mag_on`=0 next edge, `beep`=1 for 3 cycles, then IDLE.
- **Door interlock:** open the door 6 cycles into COOKING → PAUSED, `mag_on`=0, no enable pulses. Close the door and start → the next `timer_enable` comes 2 cycles later, because the counter held at 2.
- **Cancel:** in PAUSED, stop pulse → IDLE and `timer_clearn`=0 for exactly 1 cycle. In IDLE, a stop pulse gives the same single-cycle clear.
- **Start refused:** start with `door_closed`=0, or with `timer_done`=1, stays in IDLE with `mag_on`=0. Start and stop rising in the same cycle in COOKING → PAUSED.
- **Reset mid-cook:** assert `clear` during COOKING → the next edge shows IDLE with `mag_on`=0, `timer_loadn`=0, `timer_enable`=0.
